// File: rtl/fadd32_issue_arb.sv
// fadd32_issue_arb: round-robin front end that shares one pipelined fadd32 core
// among NUM_REQ requesters, each with at most one operation in flight.
module fadd32_issue_arb #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned FADD_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [32*NUM_REQ-1:0]  req_opa_i,
    input  logic [32*NUM_REQ-1:0]  req_opb_i,
    input  logic [3*NUM_REQ-1:0]   req_rm_i,
    output logic                   fadd_valid_o,
    output logic [31:0]            fadd_opa_o,
    output logic [31:0]            fadd_opb_o,
    output logic [2:0]             fadd_rm_o,
    input  logic [31:0]            fadd_res_i,
    input  logic [4:0]             fadd_fflags_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    input  logic [NUM_REQ-1:0]     rsp_ready_i,
    output logic [32*NUM_REQ-1:0]  rsp_res_o,
    output logic [5*NUM_REQ-1:0]   rsp_fflags_o,
    output logic                   idle_o
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]    busy_q, busy_d;
    logic                  fadd_valid_q, fadd_valid_d;
    logic [31:0]           fadd_opa_q, fadd_opa_d;
    logic [31:0]           fadd_opb_q, fadd_opb_d;
    logic [2:0]            fadd_rm_q, fadd_rm_d;
    logic [ID_W-1:0]       issue_id_q, issue_id_d;
    tag_t                  tag_q [FADD_LAT];
    tag_t                  tag_d [FADD_LAT];
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [32*NUM_REQ-1:0] rsp_res_q, rsp_res_d;
    logic [5*NUM_REQ-1:0]  rsp_fflags_q, rsp_fflags_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic                  grant_vld;
    logic [ID_W-1:0]       grant_id;
    logic [31:0]           sel_opa, sel_opb;
    logic [2:0]            sel_rm;
    int unsigned           arb_idx;
    logic [NUM_REQ-1:0]    rsp_hs;
    tag_t                  wb_tag;
    logic                  tag_busy;

    // Round-robin search from rr_ptr upward with wrap; first eligible requester wins.
    always_comb begin
        eligible  = req_valid_i & ~busy_q;
        grant     = '0;
        grant_vld = 1'b0;
        grant_id  = '0;
        sel_opa   = '0;
        sel_opb   = '0;
        sel_rm    = '0;
        arb_idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            arb_idx = 32'(rr_ptr_q) + k;
            if (arb_idx >= NUM_REQ) begin
                arb_idx = arb_idx - NUM_REQ;
            end
            if (!grant_vld && eligible[arb_idx] && !rst) begin
                grant_vld      = 1'b1;
                grant[arb_idx] = 1'b1;
                grant_id       = ID_W'(arb_idx);
                sel_opa        = req_opa_i[32*arb_idx +: 32];
                sel_opb        = req_opb_i[32*arb_idx +: 32];
                sel_rm         = req_rm_i[3*arb_idx +: 3];
            end
        end
    end

    // Next state: pointer, busy flags, issue register, tag pipe and writeback.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        fadd_valid_d = grant_vld;
        fadd_opa_d   = fadd_opa_q;
        fadd_opb_d   = fadd_opb_q;
        fadd_rm_d    = fadd_rm_q;
        issue_id_d   = issue_id_q;
        rsp_hs       = rsp_valid_q & rsp_ready_i;
        busy_d       = (busy_q | grant) & ~rsp_hs;
        rsp_valid_d  = rsp_valid_q & ~rsp_hs;
        rsp_res_d    = rsp_res_q;
        rsp_fflags_d = rsp_fflags_q;
        wb_tag       = tag_q[FADD_LAT-1];

        if (grant_vld) begin
            rr_ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            fadd_opa_d = sel_opa;
            fadd_opb_d = sel_opb;
            fadd_rm_d  = sel_rm;
            issue_id_d = grant_id;
        end

        // Tag enters alongside the issued op so it lines up with the core result.
        tag_d[0].valid = fadd_valid_q;
        tag_d[0].id    = issue_id_q;
        for (int unsigned s = 1; s < FADD_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wb_tag.valid && (wb_tag.id == ID_W'(i))) begin
                rsp_valid_d[i]           = 1'b1;
                rsp_res_d[32*i +: 32]    = fadd_res_i;
                rsp_fflags_d[5*i +: 5]   = fadd_fflags_i;
            end
        end
    end

    // State registers; reset drops every in-flight op and buffered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            busy_q       <= '0;
            fadd_valid_q <= 1'b0;
            fadd_opa_q   <= '0;
            fadd_opb_q   <= '0;
            fadd_rm_q    <= '0;
            issue_id_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_res_q    <= '0;
            rsp_fflags_q <= '0;
            for (int unsigned s = 0; s < FADD_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= busy_d;
            fadd_valid_q <= fadd_valid_d;
            fadd_opa_q   <= fadd_opa_d;
            fadd_opb_q   <= fadd_opb_d;
            fadd_rm_q    <= fadd_rm_d;
            issue_id_q   <= issue_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_res_q    <= rsp_res_d;
            rsp_fflags_q <= rsp_fflags_d;
            for (int unsigned s = 0; s < FADD_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    // Idle when nothing is buffered, issuing or travelling through the core.
    always_comb begin
        tag_busy = 1'b0;
        for (int unsigned s = 0; s < FADD_LAT; s++) begin
            tag_busy = tag_busy | tag_q[s].valid;
        end
    end

    assign req_ready_o  = grant;
    assign fadd_valid_o = fadd_valid_q;
    assign fadd_opa_o   = fadd_opa_q;
    assign fadd_opb_o   = fadd_opb_q;
    assign fadd_rm_o    = fadd_rm_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_res_o    = rsp_res_q;
    assign rsp_fflags_o = rsp_fflags_q;
    assign idle_o       = ~|busy_q & ~fadd_valid_q & ~tag_busy;

endmodule

// File: tb/tb_fadd32_issue_arb.sv
// Directed bench for fadd32_issue_arb (4 requesters, latency 3) plus a random
// traffic run on a 3-requester, latency-1 instance.
module tb_fadd32_issue_arb;
    localparam int N1 = 4;
    localparam int L1 = 3;
    localparam int N2 = 3;
    localparam int L2 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A signals
    logic [N1-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [32*N1-1:0] req_opa, req_opb, rsp_res;
    logic [3*N1-1:0]  req_rm;
    logic [5*N1-1:0]  rsp_fflags;
    logic             fadd_valid, idle;
    logic [31:0]      fadd_opa, fadd_opb, fadd_res;
    logic [2:0]       fadd_rm;
    logic [4:0]       fadd_fflags;

    // Instance B signals
    logic [N2-1:0]    b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [32*N2-1:0] b_req_opa, b_req_opb, b_rsp_res;
    logic [3*N2-1:0]  b_req_rm;
    logic [5*N2-1:0]  b_rsp_fflags;
    logic             b_fadd_valid, b_idle;
    logic [31:0]      b_fadd_opa, b_fadd_opb, b_fadd_res;
    logic [2:0]       b_fadd_rm;
    logic [4:0]       b_fadd_fflags;

    fadd32_issue_arb #(.NUM_REQ(N1), .FADD_LAT(L1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_opa_i(req_opa), .req_opb_i(req_opb), .req_rm_i(req_rm),
        .fadd_valid_o(fadd_valid), .fadd_opa_o(fadd_opa), .fadd_opb_o(fadd_opb),
        .fadd_rm_o(fadd_rm), .fadd_res_i(fadd_res), .fadd_fflags_i(fadd_fflags),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_res_o(rsp_res), .rsp_fflags_o(rsp_fflags), .idle_o(idle)
    );

    fadd32_issue_arb #(.NUM_REQ(N2), .FADD_LAT(L2)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_opa_i(b_req_opa), .req_opb_i(b_req_opb), .req_rm_i(b_req_rm),
        .fadd_valid_o(b_fadd_valid), .fadd_opa_o(b_fadd_opa), .fadd_opb_o(b_fadd_opb),
        .fadd_rm_o(b_fadd_rm), .fadd_res_i(b_fadd_res), .fadd_fflags_i(b_fadd_fflags),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_res_o(b_rsp_res), .rsp_fflags_o(b_rsp_fflags), .idle_o(b_idle)
    );

    // Stand-in core function returning {flags, result}; 1.5 + 1.0 gives 2.5 exactly.
    function automatic logic [36:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] rm);
        if (a == 32'h3FC00000 && b == 32'h3F800000) return {5'd0, 32'h40200000};
        return {a[4:0] ^ b[31:27] ^ {2'b00, rm}, a ^ {b[15:0], b[31:16]}};
    endfunction

    // Core models: fixed latency, free running, never reset.
    logic [36:0] c1_pipe [L1];
    always @(posedge clk) begin
        c1_pipe[0] <= core_fn(fadd_opa, fadd_opb, fadd_rm);
        for (int s = 1; s < L1; s++) c1_pipe[s] <= c1_pipe[s-1];
    end
    assign fadd_res    = c1_pipe[L1-1][31:0];
    assign fadd_fflags = c1_pipe[L1-1][36:32];

    logic [36:0] c2_q;
    always @(posedge clk) c2_q <= core_fn(b_fadd_opa, b_fadd_opb, b_fadd_rm);
    assign b_fadd_res    = c2_q[31:0];
    assign b_fadd_fflags = c2_q[36:32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] rm);
        req_valid[i]        = 1'b1;
        req_opa[32*i +: 32] = a;
        req_opb[32*i +: 32] = b;
        req_rm[3*i +: 3]    = rm;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] opa2 [4];
    logic [31:0] opb2 [4];
    logic [2:0]  rm2  [4];
    logic [36:0] exp_v;
    logic [N2-1:0] b_out, b_req_hs, b_rsp_hs;
    logic [36:0]   b_exp [N2];

    initial begin
        rst = 1'b1;
        req_valid = '0; req_opa = '0; req_opb = '0; req_rm = '0; rsp_ready = '0;
        b_req_valid = '0; b_req_opa = '0; b_req_opb = '0; b_req_rm = '0; b_rsp_ready = '0;
        opa2 = '{32'h40490FDB, 32'hC0000000, 32'h3F000001, 32'h7F7FFFFF};
        opb2 = '{32'h3E800000, 32'h41200000, 32'hBF800000, 32'h00000001};
        rm2  = '{3'd0, 3'd1, 3'd2, 3'd3};

        // Reset: nothing accepted while rst, all outputs cleared.
        req_valid = 4'b0001;
        #2;
        chk("rst_ready", 64'(req_ready), 64'd0);
        tick(); tick();
        chk("rst_fvalid", 64'(fadd_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_res", 64'(|rsp_res), 64'd0);
        chk("rst_rsp_flags", 64'(|rsp_fflags), 64'd0);
        req_valid = '0;
        rst = 1'b0;
        #1;
        chk("rst_idle", 64'(idle), 64'd1);

        // Single op on requester 0: issue at T+1, response at T+5.
        set_req(0, 32'h3FC00000, 32'h3F800000, 3'd0);
        #1;
        chk("t1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        #1;
        chk("t1_fvalid", 64'(fadd_valid), 64'd1);
        chk("t1_opa", 64'(fadd_opa), 64'h3FC00000);
        chk("t1_opb", 64'(fadd_opb), 64'h3F800000);
        chk("t1_rm", 64'(fadd_rm), 64'd0);
        chk("t1_busy_idle", 64'(idle), 64'd0);
        tick(); tick(); tick();
        #1;
        chk("t1_rsp_early", 64'(rsp_valid), 64'd0);
        chk("t1_fvalid_drop", 64'(fadd_valid), 64'd0);
        tick();
        #1;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_res", 64'(rsp_res[31:0]), 64'h40200000);
        chk("t1_rsp_flags", 64'(rsp_fflags[4:0]), 64'd0);
        rsp_ready = 4'b0001;
        tick();
        #1;
        chk("t1_rsp_done", 64'(rsp_valid), 64'd0);
        chk("t1_idle", 64'(idle), 64'd1);

        // All four requesters at once: grants 0..3, responses 5 cycles later in order.
        do_reset();
        rsp_ready = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, opa2[i], opb2[i], rm2[i]);
        #1;
        chk("t2_grant0", 64'(req_ready), 64'h1);
        for (int k = 1; k < 4; k++) begin
            tick();
            #1;
            chk("t2_grant", 64'(req_ready), 64'(4'b0001 << k));
            chk("t2_issue_opa", 64'(fadd_opa), 64'(opa2[k-1]));
        end
        tick();
        #1;
        chk("t2_all_busy", 64'(req_ready), 64'd0);
        chk("t2_issue_opa3", 64'(fadd_opa), 64'(opa2[3]));
        chk("t2_issue_rm3", 64'(fadd_rm), 64'(rm2[3]));
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            exp_v = core_fn(opa2[k], opb2[k], rm2[k]);
            chk("t2_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << k));
            chk("t2_rsp_res", 64'(rsp_res[32*k +: 32]), 64'(exp_v[31:0]));
            chk("t2_rsp_flags", 64'(rsp_fflags[5*k +: 5]), 64'(exp_v[36:32]));
            if (k == 0) chk("t2_same_cycle_block", 64'(req_ready), 64'd0);
            if (k == 1) begin
                chk("t2_regrant0", 64'(req_ready), 64'h1);
                req_valid = '0;
            end
        end
        tick();
        #1;
        chk("t2_idle", 64'(idle), 64'd1);

        // rr_ptr = 2 with requesters 0 and 3 valid: 3 first, then 0.
        set_req(1, 32'h11111111, 32'h22222222, 3'd4);
        #1;
        chk("t3_set_ptr", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        set_req(0, 32'h33333333, 32'h44444444, 3'd0);
        set_req(3, 32'h55555555, 32'h66666666, 3'd1);
        #1;
        chk("t3_first", 64'(req_ready), 64'h8);
        tick();
        #1;
        chk("t3_second", 64'(req_ready), 64'h1);
        chk("t3_issue3", 64'(fadd_opa), 64'h55555555);
        tick();
        req_valid = '0;
        #1;
        chk("t3_issue0", 64'(fadd_opa), 64'h33333333);
        repeat (8) tick();
        #1;
        chk("t3_idle", 64'(idle), 64'd1);

        // Requester 1 back-pressures its response for 20 cycles.
        rsp_ready = 4'b1101;
        set_req(1, 32'hA5A50000, 32'h5A5A0001, 3'd2);
        #1;
        chk("t4_grant", 64'(req_ready), 64'h2);
        tick();
        set_req(1, 32'h0BADF00D, 32'h12345678, 3'd1);
        #1;
        chk("t4_busy_block", 64'(req_ready), 64'd0);
        tick(); tick(); tick();
        #1;
        chk("t4_rsp_early", 64'(rsp_valid), 64'd0);
        tick();
        exp_v = core_fn(32'hA5A50000, 32'h5A5A0001, 3'd2);
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("t4_hold_valid", 64'(rsp_valid), 64'h2);
            chk("t4_hold_res", 64'(rsp_res[63:32]), 64'(exp_v[31:0]));
            chk("t4_hold_flags", 64'(rsp_fflags[9:5]), 64'(exp_v[36:32]));
            chk("t4_hold_noready", 64'(req_ready[1]), 64'd0);
            tick();
        end
        rsp_ready = 4'b1111;
        #1;
        chk("t4_hs_cycle_ready", 64'(req_ready), 64'd0);
        tick();
        #1;
        chk("t4_rsp_cleared", 64'(rsp_valid), 64'd0);
        chk("t4_next_grant", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        #1;
        chk("t4_next_issue", 64'(fadd_valid), 64'd1);
        chk("t4_next_opa", 64'(fadd_opa), 64'h0BADF00D);
        chk("t4_next_rm", 64'(fadd_rm), 64'd1);
        repeat (8) tick();
        #1;
        chk("t4_idle", 64'(idle), 64'd1);

        // Reset with three ops in the tag pipe; pointer is at 2 so grants are 2,0,1.
        set_req(0, 32'h01010101, 32'h02020202, 3'd0);
        set_req(1, 32'h03030303, 32'h04040404, 3'd0);
        set_req(2, 32'h05050505, 32'h06060606, 3'd0);
        #1;
        chk("t5_grant_a", 64'(req_ready), 64'h4);
        tick();
        #1;
        chk("t5_grant_b", 64'(req_ready), 64'h1);
        tick();
        #1;
        chk("t5_grant_c", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_fvalid", 64'(fadd_valid), 64'd0);
        chk("t5_rst_rsp", 64'(rsp_valid), 64'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("t5_no_stale_rsp", 64'(rsp_valid), 64'd0);
            chk("t5_idle", 64'(idle), 64'd1);
            tick();
        end
        for (int i = 0; i < 4; i++) set_req(i, 32'h0, 32'h0, 3'd0);
        #1;
        chk("t5_first_grant", 64'(req_ready), 64'h1);
        req_valid = '0;
        tick();

        // Random traffic on the 3-requester, latency-1 instance with a scoreboard.
        b_out = '0;
        for (int i = 0; i < N2; i++) b_exp[i] = '0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            for (int i = 0; i < N2; i++) begin
                if (cyc < 400 && !b_req_valid[i] && $urandom_range(0, 1) == 1) begin
                    b_req_valid[i]        = 1'b1;
                    b_req_opa[32*i +: 32] = $urandom;
                    b_req_opb[32*i +: 32] = $urandom;
                    b_req_rm[3*i +: 3]    = 3'($urandom_range(0, 4));
                end
            end
            b_rsp_ready = (cyc < 400) ? 3'($urandom_range(0, 7)) : 3'b111;
            #1;
            chk("b_ready_onehot0", 64'($onehot0(b_req_ready)), 64'd1);
            b_req_hs = b_req_valid & b_req_ready;
            b_rsp_hs = b_rsp_valid & b_rsp_ready;
            for (int i = 0; i < N2; i++) begin
                if (b_rsp_hs[i]) begin
                    chk("b_rsp_has_owner", 64'(b_out[i]), 64'd1);
                    chk("b_route_res", 64'(b_rsp_res[32*i +: 32]), 64'(b_exp[i][31:0]));
                    chk("b_route_flags", 64'(b_rsp_fflags[5*i +: 5]), 64'(b_exp[i][36:32]));
                end
                if (b_req_hs[i]) chk("b_one_outstanding", 64'(b_out[i]), 64'd0);
            end
            for (int i = 0; i < N2; i++) begin
                if (b_rsp_hs[i]) b_out[i] = 1'b0;
                if (b_req_hs[i]) begin
                    b_out[i] = 1'b1;
                    b_exp[i] = core_fn(b_req_opa[32*i +: 32], b_req_opb[32*i +: 32],
                                       b_req_rm[3*i +: 3]);
                end
            end
            tick();
            b_req_valid = b_req_valid & ~b_req_hs;
        end
        #1;
        chk("b_none_lost", 64'(b_out), 64'd0);
        chk("b_drained", 64'(b_req_valid), 64'd0);
        chk("b_idle", 64'(b_idle), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
